// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the datapath, mem_access_ctrl and the ram512x8 byte-lane RAM.
//
// Handshake semantics:
//   datapath side - req is a request strobe seen only while the controller is idle
//                   (busy=0 and done=0). The fields are captured on that same edge.
//                   done is a one-cycle pulse that closes the transaction, and fault
//                   is valid in that cycle.
//   RAM side      - a four-phase handshake. ram_en rises with stable
//                   rw/adr/data/size/place. The RAM raises ram_finished, then
//                   ram_en drops. The controller waits for ram_finished to fall
//                   before it can start another access.
// The master modport is the controller's view. The slave modport is the
// environment's view (datapath plus RAM).
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 9
);
   logic              req;
   logic              wr;
   logic [1:0]        size;
   logic              sign_ext;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              done;
   logic [1:0]        fault;
   logic              busy;
   logic              ram_en;
   logic              ram_rw;
   logic [ADDR_W-1:0] ram_adr;
   logic [31:0]       ram_data;
   logic [1:0]        ram_size;
   logic [1:0]        ram_place;
   logic [31:0]       ram_out;
   logic              ram_finished;

   modport master (
      input  req, wr, size, sign_ext, addr, wdata, ram_out, ram_finished,
      output rdata, done, fault, busy,
      output ram_en, ram_rw, ram_adr, ram_data, ram_size, ram_place
   );

   modport slave (
      output req, wr, size, sign_ext, addr, wdata, ram_out, ram_finished,
      input  rdata, done, fault, busy,
      input  ram_en, ram_rw, ram_adr, ram_data, ram_size, ram_place
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Initiator-side load/store controller for the ram512x8 byte-lane RAM.
// It checks alignment, runs the RAM en/finished handshake with a timeout,
// extends load data, and reports done/fault to the control unit.
// The request is captured in IDLE. On the following edge the controller decides
// between a misaligned fault and a RAM access, so ram_en rises one edge after req
// is sampled.
module mem_access_ctrl #(
   parameter int ADDR_W  = 9,
   parameter int TIMEOUT = 64
) (
   input  logic                clk,
   input  logic                reset,
   mem_access_ctrl_if.master   bus,
   output logic [1:0]          dbg_state
);
   typedef enum logic [1:0] {IDLE, ACCESS, RELEASE, DONE} state_t;

   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   state_t            state, state_nxt;
   logic              req_q;
   logic              l_wr;
   logic [1:0]        l_size;
   logic              l_sign;
   logic [ADDR_W-1:0] l_addr;
   logic [31:0]       l_wdata;
   logic [CW-1:0]     cnt;
   logic [1:0]        pend_fault;
   logic [1:0]        fault_q;
   logic [31:0]       rdata_q;
   logic              ram_en_q;
   logic              ram_rw_q;
   logic [ADDR_W-1:0] ram_adr_q;
   logic [31:0]       ram_data_q;
   logic [1:0]        ram_size_q;
   logic [1:0]        ram_place_q;
   logic              misaligned;
   logic [1:0]        place;
   logic [31:0]       ext_data;

   // Alignment check and byte-lane select, both taken from the latched request
   always_comb begin
      misaligned = 1'b0;
      place      = 2'b00;
      case (l_size)
         2'b00: place = l_addr[1:0];
         2'b01: begin
            place      = {l_addr[1], 1'b0};
            misaligned = l_addr[0];
         end
         2'b10: misaligned = (l_addr[1:0] != 2'b00);
         default: misaligned = 1'b1;
      endcase
   end

   // Zero or sign extension of the right-justified RAM read data
   always_comb begin
      ext_data = bus.ram_out;
      case (ram_size_q)
         2'b00: ext_data = {{24{l_sign & bus.ram_out[7]}}, bus.ram_out[7:0]};
         2'b01: ext_data = {{16{l_sign & bus.ram_out[15]}}, bus.ram_out[15:0]};
         default: ext_data = bus.ram_out;
      endcase
   end

   // Next-state logic for the access FSM
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_q) state_nxt = misaligned ? DONE : ACCESS;
         ACCESS:  if (bus.ram_finished || cnt == LAST) state_nxt = RELEASE;
         RELEASE: if (!bus.ram_finished) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register, request latch, RAM drive registers, timeout counter and result registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         req_q       <= 1'b0;
         l_wr        <= 1'b0;
         l_size      <= 2'b00;
         l_sign      <= 1'b0;
         l_addr      <= '0;
         l_wdata     <= '0;
         cnt         <= '0;
         pend_fault  <= 2'b00;
         fault_q     <= 2'b00;
         rdata_q     <= '0;
         ram_en_q    <= 1'b0;
         ram_rw_q    <= 1'b0;
         ram_adr_q   <= '0;
         ram_data_q  <= '0;
         ram_size_q  <= 2'b00;
         ram_place_q <= 2'b00;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (req_q) begin
                  req_q <= 1'b0;
                  if (misaligned) begin
                     fault_q <= 2'b01;
                  end else begin
                     ram_en_q    <= 1'b1;
                     ram_rw_q    <= ~l_wr;
                     ram_adr_q   <= l_addr;
                     ram_data_q  <= l_wdata;
                     ram_size_q  <= l_size;
                     ram_place_q <= place;
                     cnt         <= '0;
                  end
               end else if (bus.req) begin
                  req_q   <= 1'b1;
                  l_wr    <= bus.wr;
                  l_size  <= bus.size;
                  l_sign  <= bus.sign_ext;
                  l_addr  <= bus.addr;
                  l_wdata <= bus.wdata;
               end
            end
            ACCESS: begin
               cnt <= cnt + CW'(1);
               // A finish on the last allowed cycle still counts as a success
               if (bus.ram_finished) begin
                  if (ram_rw_q) rdata_q <= ext_data;
                  pend_fault <= 2'b00;
                  ram_en_q   <= 1'b0;
               end else if (cnt == LAST) begin
                  pend_fault <= 2'b10;
                  ram_en_q   <= 1'b0;
               end
            end
            RELEASE: if (!bus.ram_finished) fault_q <= pend_fault;
            default: ;
         endcase
      end
   end

   assign bus.rdata     = rdata_q;
   assign bus.fault     = fault_q;
   assign bus.done      = (state == DONE);
   assign bus.busy      = (state == ACCESS) || (state == RELEASE);
   assign bus.ram_en    = ram_en_q;
   assign bus.ram_rw    = ram_rw_q;
   assign bus.ram_adr   = ram_adr_q;
   assign bus.ram_data  = ram_data_q;
   assign bus.ram_size  = ram_size_q;
   assign bus.ram_place = ram_place_q;
   assign dbg_state     = state;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl. A transaction-level model predicts, for
// every cycle after a request, ram_en/busy/done and the RAM fields. It also
// predicts when rdata and fault change. A small RAM responder answers ram_en
// after a per-vector latency and drops ram_finished after a per-vector release delay.
module tb_mem_access_ctrl;
   localparam int ADDR_W  = 9;
   localparam int TIMEOUT = 64;

   typedef struct {
      logic              wr;
      logic [1:0]        size;
      logic              sx;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       wdata;
      logic [31:0]       rout;
      int                lat;        // 0 = RAM never finishes
      int                rel;        // cycles ram_finished stays high after ram_en falls
      logic [1:0]        exp_fault;
      logic [31:0]       exp_rdata;
      logic [1:0]        exp_place;
   } vec_t;

   logic       clk;
   logic       reset;
   logic [1:0] dbg_state;

   mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   mem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // model state
   vec_t        cur;
   logic        txn_valid = 1'b0;
   logic        chk_on    = 1'b0;
   int          t_start   = 0;
   int          cur_en_len, cur_done, cur_rd;
   logic [1:0]  cur_fault;
   logic [31:0] model_rdata = '0;
   logic [1:0]  model_fault = '0;
   vec_t        vecs[$];

   // clock/reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic bad_align(input logic [1:0] s, input logic [ADDR_W-1:0] a);
      int unsigned ai;
      ai = a;
      if (s == 2'd3) return 1'b1;
      if (s == 2'd1) return (ai % 2) != 0;
      if (s == 2'd2) return (ai % 4) != 0;
      return 1'b0;
   endfunction

   function automatic logic [1:0] lane(input logic [1:0] s, input logic [ADDR_W-1:0] a);
      int unsigned ai;
      ai = a;
      if (s == 2'd0) return 2'(ai % 4);
      if (s == 2'd1) return 2'((ai % 4) / 2 * 2);
      return 2'd0;
   endfunction

   function automatic logic [31:0] extend(input logic [1:0] s, input logic sx, input logic [31:0] r);
      longint unsigned v;
      if (s == 2'd0) begin
         v = r % 256;
         if (sx && v >= 128) v = v + 64'hFFFF_FF00;
      end else if (s == 2'd1) begin
         v = r % 65536;
         if (sx && v >= 32768) v = v + 64'hFFFF_0000;
      end else begin
         v = r;
      end
      return 32'(v);
   endfunction

   // RAM responder: finishes lat cycles after ram_en rises, releases rel cycles after it falls
   int   hi_cnt = 0;
   int   lo_cnt = 0;
   logic fin    = 1'b0;
   always @(negedge clk) begin
      if (reset) begin
         hi_cnt = 0;
         lo_cnt = 0;
         fin    = 1'b0;
      end else if (bus.ram_en) begin
         hi_cnt++;
         lo_cnt = 0;
         if (cur.lat != 0 && hi_cnt == cur.lat) fin = 1'b1;
      end else begin
         hi_cnt = 0;
         if (fin) begin
            lo_cnt++;
            if (lo_cnt >= cur.rel) begin
               fin    = 1'b0;
               lo_cnt = 0;
            end
         end
      end
      bus.ram_finished = fin;
   end

   // scoreboard: per-cycle comparison against the transaction model
   task automatic check_cycle();
      int   k;
      logic e_en, e_busy, e_done;
      k      = 0;
      e_en   = 1'b0;
      e_busy = 1'b0;
      e_done = 1'b0;
      if (txn_valid) begin
         k      = cyc - t_start;
         e_en   = (k >= 1) && (k <= cur_en_len);
         e_busy = (k >= 1) && (k < cur_done);
         e_done = (k == cur_done);
         if (k == cur_rd) model_rdata = extend(cur.size, cur.sx, cur.rout);
         if (k == cur_done) model_fault = cur_fault;
      end
      chk("ram_en", 32'(bus.ram_en), 32'(e_en));
      chk("busy", 32'(bus.busy), 32'(e_busy));
      chk("done", 32'(bus.done), 32'(e_done));
      chk("fault", 32'(bus.fault), 32'(model_fault));
      chk("rdata", bus.rdata, model_rdata);
      if (e_en) begin
         chk("ram_rw", 32'(bus.ram_rw), 32'(!cur.wr));
         chk("ram_adr", 32'(bus.ram_adr), 32'(cur.addr));
         chk("ram_data", bus.ram_data, cur.wdata);
         chk("ram_size", 32'(bus.ram_size), 32'(cur.size));
         chk("ram_place", 32'(bus.ram_place), 32'(lane(cur.size, cur.addr)));
         if (k == 1) chk("ram_place_lit", 32'(bus.ram_place), 32'(cur.exp_place));
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (chk_on) check_cycle();
   end

   // driver: start a transaction and load the model's expectations for it
   task automatic start_txn(input vec_t v);
      logic mis, tmo;
      @(negedge clk);
      cur        = v;
      mis        = bad_align(v.size, v.addr);
      tmo        = !mis && (v.lat == 0 || v.lat > TIMEOUT);
      cur_en_len = mis ? 0 : (tmo ? TIMEOUT : v.lat);
      cur_done   = mis ? 1 : (tmo ? TIMEOUT + 2 : v.lat + v.rel + 1);
      cur_rd     = (!mis && !tmo && !v.wr) ? v.lat + 1 : -1;
      cur_fault  = mis ? 2'b01 : (tmo ? 2'b10 : 2'b00);
      t_start    = cyc + 1;
      txn_valid  = 1'b1;
      bus.req      = 1'b1;
      bus.wr       = v.wr;
      bus.size     = v.size;
      bus.sign_ext = v.sx;
      bus.addr     = v.addr;
      bus.wdata    = v.wdata;
      bus.ram_out  = v.rout;
      @(negedge clk);
      // scramble the live inputs: the controller must use its latched copies
      bus.req      = 1'b0;
      bus.wr       = 1'($urandom_range(0, 1));
      bus.size     = 2'($urandom_range(0, 3));
      bus.sign_ext = 1'($urandom_range(0, 1));
      bus.addr     = ADDR_W'($urandom_range(0, 511));
      bus.wdata    = $urandom();
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic got;
      start_txn(v);
      got = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (bus.done) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!got) begin
         failures++;
         $display("FAIL done_wait vec %0d: no done within 200 cycles", idx);
      end else begin
         chk($sformatf("fault_lit[%0d]", idx), 32'(bus.fault), 32'(v.exp_fault));
         chk($sformatf("rdata_lit[%0d]", idx), bus.rdata, v.exp_rdata);
      end
      @(negedge clk);
   endtask

   task automatic add(input logic wr, input logic [1:0] size, input logic sx,
                      input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rout, input int lat, input int rel,
                      input logic [1:0] ef, input logic [31:0] er, input logic [1:0] ep);
      vec_t v;
      v.wr = wr; v.size = size; v.sx = sx; v.addr = addr; v.wdata = wdata;
      v.rout = rout; v.lat = lat; v.rel = rel;
      v.exp_fault = ef; v.exp_rdata = er; v.exp_place = ep;
      vecs.push_back(v);
   endtask

   initial begin
      bus.req = 1'b0; bus.wr = 1'b0; bus.size = 2'b00; bus.sign_ext = 1'b0;
      bus.addr = '0; bus.wdata = '0; bus.ram_out = '0; bus.ram_finished = 1'b0;
      cur = '{default: '0};
      reset = 1'b1;

      //   wr  sz    sx  addr      wdata         rout          lat rel fault rdata          place
      add(1, 2'd0, 0, 9'h003, 32'h0000_00A5, 32'h0,         2,  2,  2'd0, 32'h0000_0000, 2'd3);
      add(0, 2'd0, 1, 9'h003, 32'h0,         32'h0000_00A5, 1,  1,  2'd0, 32'hFFFF_FFA5, 2'd3);
      add(0, 2'd0, 0, 9'h003, 32'h0,         32'h0000_00A5, 3,  2,  2'd0, 32'h0000_00A5, 2'd3);
      add(1, 2'd1, 0, 9'h002, 32'h0000_8001, 32'h0,         2,  1,  2'd0, 32'h0000_00A5, 2'd2);
      add(0, 2'd1, 1, 9'h002, 32'h0,         32'h0000_8001, 1,  2,  2'd0, 32'hFFFF_8001, 2'd2);
      add(1, 2'd2, 0, 9'h004, 32'hDEAD_BEEF, 32'h0,         4,  1,  2'd0, 32'hFFFF_8001, 2'd0);
      add(0, 2'd2, 1, 9'h004, 32'h0,         32'hDEAD_BEEF, 2,  3,  2'd0, 32'hDEAD_BEEF, 2'd0);
      add(0, 2'd1, 0, 9'h001, 32'h0,         32'h0,         1,  1,  2'd1, 32'hDEAD_BEEF, 2'd0);
      add(0, 2'd3, 0, 9'h000, 32'h0,         32'h0,         1,  1,  2'd1, 32'hDEAD_BEEF, 2'd0);
      add(0, 2'd1, 0, 9'h102, 32'h0,         32'hABCD_7F00, 1,  1,  2'd0, 32'h0000_7F00, 2'd2);
      add(0, 2'd0, 1, 9'h1FE, 32'h0,         32'h1234_5678, 64, 1,  2'd0, 32'h0000_0078, 2'd2);
      add(1, 2'd2, 0, 9'h006, 32'h1,         32'h0,         1,  1,  2'd1, 32'h0000_0078, 2'd0);
      add(0, 2'd2, 0, 9'h008, 32'h0,         32'hFFFF_FFFF, 0,  1,  2'd2, 32'h0000_0078, 2'd0);
      add(1, 2'd0, 1, 9'h1FF, 32'hFFFF_FF80, 32'h0,         1,  1,  2'd0, 32'h0000_0078, 2'd3);
      add(0, 2'd2, 1, 9'h000, 32'h0,         32'h8000_0000, 1,  1,  2'd0, 32'h8000_0000, 2'd0);

      // reset state
      @(negedge clk);
      chk("rst_rdata", bus.rdata, 32'h0);
      chk("rst_done", 32'(bus.done), 32'h0);
      chk("rst_fault", 32'(bus.fault), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_ram_en", 32'(bus.ram_en), 32'h0);
      chk("rst_ram_rw", 32'(bus.ram_rw), 32'h0);
      chk("rst_ram_adr", 32'(bus.ram_adr), 32'h0);
      chk("rst_ram_data", bus.ram_data, 32'h0);
      chk("rst_ram_size", 32'(bus.ram_size), 32'h0);
      chk("rst_ram_place", 32'(bus.ram_place), 32'h0);
      chk("rst_state", 32'(dbg_state), 32'h0);
      reset  = 1'b0;
      chk_on = 1'b1;
      repeat (2) @(negedge clk);

      foreach (vecs[i]) run_vec(vecs[i], i);

      // reset during ACCESS: ram_en drops at once and no done appears
      start_txn('{wr: 1'b0, size: 2'd2, sx: 1'b0, addr: 9'h010, wdata: 32'h0,
                  rout: 32'h0, lat: 0, rel: 1, exp_fault: 2'd0, exp_rdata: 32'h0,
                  exp_place: 2'd0});
      repeat (5) @(negedge clk);
      chk("pre_rst_en", 32'(bus.ram_en), 32'h1);
      chk_on = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("arst_ram_en", 32'(bus.ram_en), 32'h0);
      chk("arst_busy", 32'(bus.busy), 32'h0);
      chk("arst_done", 32'(bus.done), 32'h0);
      chk("arst_rdata", bus.rdata, 32'h0);
      chk("arst_fault", 32'(bus.fault), 32'h0);
      txn_valid   = 1'b0;
      model_rdata = '0;
      model_fault = '0;
      repeat (2) @(negedge clk);
      reset  = 1'b0;
      chk_on = 1'b1;
      repeat (6) @(negedge clk);
      chk_on = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
